// File: rtl/hs_source.sv
// FIFO-buffered operand source for the picoMIPS switch port.
// Ports: clk/reset, in_* push side, ld_ack from CPU, sw_data/handshake_switch out, busy, count.
module hs_source #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 4,
  parameter int SETUP_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         ld_ack,
  output logic [DATA_WIDTH-1:0]        sw_data,
  output logic                         handshake_switch,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);
  localparam int SW   = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES) : 1;

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("hs_source: SETUP_CYCLES must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hs_source: DEPTH must be a power of two, at least 2");
  end

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    PRESENT
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]       count_q, count_d;
  logic [SW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sw_data_q, sw_data_d;
  logic                  hs_q, hs_d;
  logic                  push, pop;

  // Ready depends on occupancy only; a same-cycle pop does not open a slot.
  assign in_ready = count_q < CNTW'(DEPTH);
  assign push     = in_valid && in_ready;

  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    cnt_d     = cnt_q;
    sw_data_d = sw_data_q;
    hs_d      = hs_q;
    pop       = 1'b0;

    if (push) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          sw_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + 1'b1;
          cnt_d     = SW'(SETUP_CYCLES - 1);
          state_d   = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          // Toggle gives the 1,0,1,... phase per word.
          hs_d    = ~hs_q;
          state_d = PRESENT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PRESENT: begin
        if (ld_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cnt_q     <= '0;
      sw_data_q <= '0;
      hs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      cnt_q     <= cnt_d;
      sw_data_q <= sw_data_d;
      hs_q      <= hs_d;
    end
  end

  assign sw_data          = sw_data_q;
  assign handshake_switch = hs_q;
  assign busy             = state_q != IDLE;
  assign count            = count_q;

endmodule

// File: tb/tb_hs_source.sv
// Directed bench for hs_source at default parameters.
// Checks reset, timing, back-pressure, spurious ack and mid-run reset.
module tb_hs_source;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       ld_ack = 1'b0;
  logic [7:0] sw_data;
  logic       handshake_switch;
  logic       busy;
  logic [2:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  hs_source dut (
    .clk              (clk),
    .reset            (reset),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .ld_ack           (ld_ack),
    .sw_data          (sw_data),
    .handshake_switch (handshake_switch),
    .busy             (busy),
    .count            (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    ld_ack   = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Wait (bounded) for the word to be presented, check it, then ack it.
  task automatic serve(input logic [7:0] d, input logic h);
    int n;
    n = 0;
    while (handshake_switch !== h && n < 20) begin
      tick();
      n++;
    end
    chk("serve_hs", {31'd0, handshake_switch}, {31'd0, h});
    chk("serve_sw", {24'd0, sw_data}, {24'd0, d});
    chk("serve_busy", {31'd0, busy}, 32'd1);
    ld_ack = 1'b1;
    tick();
    ld_ack = 1'b0;
    chk("serve_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_sw", {24'd0, sw_data}, 32'h00);
    chk("rst_hs", {31'd0, handshake_switch}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // Single word: exact latency
    in_data = 8'h12; in_valid = 1'b1;
    tick();                                   // edge 0
    in_valid = 1'b0;
    chk("sw_e0_count", {29'd0, count}, 32'd1);
    chk("sw_e0_busy", {31'd0, busy}, 32'd0);
    tick();                                   // edge 1
    chk("sw_e1_data", {24'd0, sw_data}, 32'h12);
    chk("sw_e1_busy", {31'd0, busy}, 32'd1);
    chk("sw_e1_count", {29'd0, count}, 32'd0);
    tick();                                   // edge 2
    chk("sw_e2_hs", {31'd0, handshake_switch}, 32'd0);
    tick();                                   // edge 3
    chk("sw_e3_hs", {31'd0, handshake_switch}, 32'd1);
    tick();
    tick();                                   // edge 5
    chk("sw_e5_busy", {31'd0, busy}, 32'd1);
    ld_ack = 1'b1;
    tick();                                   // edge 6
    ld_ack = 1'b0;
    chk("sw_e6_busy", {31'd0, busy}, 32'd0);
    chk("sw_e6_hs", {31'd0, handshake_switch}, 32'd1);
    chk("sw_e6_data", {24'd0, sw_data}, 32'h12);

    // Two words
    do_reset();
    in_data = 8'h12; in_valid = 1'b1;
    tick();                                   // edge 0
    in_data = 8'h34;
    tick();                                   // edge 1: push + pop
    in_valid = 1'b0;
    chk("tw_e1_count", {29'd0, count}, 32'd1);
    chk("tw_e1_data", {24'd0, sw_data}, 32'h12);
    tick();
    tick();                                   // edge 3
    chk("tw_e3_hs", {31'd0, handshake_switch}, 32'd1);
    ld_ack = 1'b1;
    tick();                                   // edge 4
    ld_ack = 1'b0;
    chk("tw_e4_busy", {31'd0, busy}, 32'd0);
    tick();                                   // edge 5
    chk("tw_e5_data", {24'd0, sw_data}, 32'h34);
    chk("tw_e5_hs", {31'd0, handshake_switch}, 32'd1);
    tick();
    chk("tw_e6_hs", {31'd0, handshake_switch}, 32'd1);
    tick();                                   // edge 7
    chk("tw_e7_hs", {31'd0, handshake_switch}, 32'd0);
    chk("tw_e7_count", {29'd0, count}, 32'd0);

    // Back-pressure: six words, no ack
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 8'(i + 1);
      tick();                                 // edges 0..4
    end
    in_data = 8'h06;
    tick();                                   // edge 5: blocked
    chk("bp_count", {29'd0, count}, 32'd4);
    chk("bp_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_data", {24'd0, sw_data}, 32'h01);
    chk("bp_hs", {31'd0, handshake_switch}, 32'd1);
    tick();                                   // edge 6
    chk("bp_e6_count", {29'd0, count}, 32'd4);
    ld_ack = 1'b1;
    tick();                                   // edge 7: ack, full
    ld_ack = 1'b0;
    chk("bp_e7_count", {29'd0, count}, 32'd4);
    chk("bp_e7_busy", {31'd0, busy}, 32'd0);
    tick();                                   // edge 8: pop only
    chk("bp_e8_count", {29'd0, count}, 32'd3);
    chk("bp_e8_data", {24'd0, sw_data}, 32'h02);
    chk("bp_e8_ready", {31'd0, in_ready}, 32'd1);
    tick();                                   // edge 9: 0x06 accepted
    in_valid = 1'b0;
    chk("bp_e9_count", {29'd0, count}, 32'd4);
    serve(8'h02, 1'b0);
    serve(8'h03, 1'b1);
    serve(8'h04, 1'b0);
    serve(8'h05, 1'b1);
    serve(8'h06, 1'b0);
    chk("bp_drain_count", {29'd0, count}, 32'd0);

    // Spurious ack in IDLE and SETUP
    do_reset();
    ld_ack = 1'b1;
    tick();
    ld_ack = 1'b0;
    chk("sp_idle_busy", {31'd0, busy}, 32'd0);
    chk("sp_idle_hs", {31'd0, handshake_switch}, 32'd0);
    chk("sp_idle_sw", {24'd0, sw_data}, 32'h00);
    in_data = 8'hAB; in_valid = 1'b1;
    tick();                                   // edge 0
    in_valid = 1'b0;
    tick();                                   // edge 1: SETUP
    ld_ack = 1'b1;
    tick();                                   // edge 2: ack in SETUP
    ld_ack = 1'b0;
    chk("sp_setup_busy", {31'd0, busy}, 32'd1);
    chk("sp_setup_hs", {31'd0, handshake_switch}, 32'd0);
    chk("sp_setup_sw", {24'd0, sw_data}, 32'hAB);
    tick();                                   // edge 3
    chk("sp_e3_hs", {31'd0, handshake_switch}, 32'd1);
    chk("sp_e3_busy", {31'd0, busy}, 32'd1);
    ld_ack = 1'b1;
    tick();
    ld_ack = 1'b0;
    chk("sp_done_busy", {31'd0, busy}, 32'd0);

    // Reset while PRESENT with three queued words
    do_reset();
    in_valid = 1'b1;
    in_data = 8'h11; tick();
    in_data = 8'h22; tick();
    in_data = 8'h33; tick();
    in_data = 8'h44; tick();                  // edge 3
    chk("mr_count", {29'd0, count}, 32'd3);
    chk("mr_hs", {31'd0, handshake_switch}, 32'd1);
    in_data = 8'h99;
    ld_ack  = 1'b1;
    reset   = 1'b1;
    tick();
    reset    = 1'b0;
    ld_ack   = 1'b0;
    in_valid = 1'b0;
    chk("mr_rst_hs", {31'd0, handshake_switch}, 32'd0);
    chk("mr_rst_count", {29'd0, count}, 32'd0);
    chk("mr_rst_busy", {31'd0, busy}, 32'd0);
    chk("mr_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_rst_sw", {24'd0, sw_data}, 32'h00);
    in_data = 8'h55; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    serve(8'h55, 1'b1);
    chk("mr_end_count", {29'd0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
